id_ex_hazard_ctrl: RTL and testbench
====================================

ID_EX_HAZARD_CTRL -- requirements
Module: id_ex_hazard_ctrl

Interface
REQ-001 SHALL provide parameter FLUSH_CYCLES, default 2, meaning the number of cycles IF/ID and ID/EX are squashed after a taken branch (legal range 1..7).
REQ-002 SHALL provide parameter CNT_W, default 16, meaning the width of the saturating event counters.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemRead_1  input  1  MemRead as registered in the ID/EX stage (instruction now in EX).
REQ-006 Rd_1  input  5  destination register as registered in the ID/EX stage.
REQ-007 Rs_ID  input  5  source register rs of the instruction in ID.
REQ-008 Rt_ID  input  5  source register rt of the instruction in ID.
REQ-009 UsesRt_ID  input  1  instruction in ID reads rt.
REQ-010 BranchTaken  input  1  branch resolved taken this cycle.
REQ-011 PCWrite  output  1  PC update enable.
REQ-012 IFIDWrite  output  1  IF/ID register load enable.
REQ-013 IFIDFlush  output  1  IF/ID register clear enable.
REQ-014 IDEXFlush  output  1  forces all ID/EX control fields (Regwrite, MemToReg, MemWrite, MemRead, Branch) to 0 on the next edge.
REQ-015 StallCount  output  CNT_W  number of load-use stalls taken.
REQ-016 FlushCount  output  CNT_W  number of branch squashes started.

Function
REQ-017 SHALL implement states RUN, BUBBLE, SQUASH, plus a squash counter of 3 bits.
REQ-018 Load-use hazard (LU) SHALL be MemRead_1 && Rd_1 != 0 && (Rd_1 == Rs_ID || (UsesRt_ID && Rd_1 == Rt_ID)).
REQ-019 RUN, no BranchTaken, no LU: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0; stay RUN.
REQ-020 RUN, LU, no BranchTaken: same cycle (combinational) PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0; next state BUBBLE; StallCount increments.
REQ-021 BUBBLE: normal outputs as REQ-019, LU evaluation suppressed; next state RUN unless BranchTaken.
REQ-022 RUN or BUBBLE with BranchTaken: same cycle PCWrite=1, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1; BranchTaken SHALL take priority over LU; FlushCount increments; if FLUSH_CYCLES==1 next state RUN, else next state SQUASH with counter loaded to FLUSH_CYCLES-2.
REQ-023 SQUASH: PCWrite=1, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1; LU and BranchTaken ignored; counter decrements each cycle; at counter 0 next state RUN.
REQ-024 Squash therefore SHALL span exactly FLUSH_CYCLES consecutive cycles including the BranchTaken cycle.
REQ-025 StallCount and FlushCount SHALL saturate at all-ones and never wrap.
REQ-026 Outputs PCWrite, IFIDWrite, IFIDFlush, IDEXFlush SHALL be combinational from state and inputs; counters SHALL be registered.

Reset
REQ-027 While reset is high: state RUN, squash counter 0, StallCount 0, FlushCount 0, PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1.
REQ-028 Reset asserted mid-BUBBLE or mid-SQUASH SHALL abort the sequence immediately; first cycle after deassertion SHALL be evaluated as RUN.

Structure
REQ-029 State encoding (RUN=2'b00, BUBBLE=2'b01, SQUASH=2'b10) and the register-zero constant SHALL live in the shared pipeline package used by the pipeline registers.
REQ-030 One sub-module SHALL be used: sat_counter (width-parameterised saturating incrementer with async reset), instantiated twice.

Verification
REQ-031 MemRead_1=1, Rd_1=5, Rs_ID=5 in RUN -> that cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle BUBBLE with normal outputs; StallCount=1.
REQ-032 MemRead_1=1, Rd_1=0, Rs_ID=0 -> no stall, StallCount stays 0; Rd_1=7, Rt_ID=7, UsesRt_ID=0 -> no stall.
REQ-033 BranchTaken=1 together with LU, FLUSH_CYCLES=2 -> IFIDFlush=IDEXFlush=1 for exactly 2 cycles, PCWrite=1 throughout, StallCount unchanged, FlushCount=1.
REQ-034 BranchTaken asserted during SQUASH, FLUSH_CYCLES=3 -> squash still ends after 3 cycles total, FlushCount=1.
REQ-035 Reset pulsed in second SQUASH cycle -> outputs take REQ-027 values asynchronously; after release state RUN, counters 0.
REQ-036 CNT_W=4, 20 back-to-back load-use events -> StallCount holds 15.

Source files
------------

// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register-zero constant,
// control bundle type and the load-use hazard detector.
package id_ex_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StBubble = 2'b01,
        StSquash = 2'b10
    } hz_state_e;

    localparam logic [4:0] RegZero = 5'd0;
    localparam int unsigned SquashCntW = 3;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CtrlNormal = '{pc_write: 1'b1, ifid_write: 1'b1,
                                        ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam hz_ctrl_t CtrlStall  = '{pc_write: 1'b0, ifid_write: 1'b0,
                                        ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam hz_ctrl_t CtrlSquash = '{pc_write: 1'b1, ifid_write: 1'b0,
                                        ifid_flush: 1'b1, idex_flush: 1'b1};
    localparam hz_ctrl_t CtrlReset  = '{pc_write: 1'b0, ifid_write: 1'b0,
                                        ifid_flush: 1'b1, idex_flush: 1'b1};

    // A load in EX whose result the instruction in ID needs; $zero never hazards.
    function automatic logic load_use(input logic       mem_read,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
        return mem_read && (rd != RegZero) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/id_ex_hazard_ctrl_sat_counter.sv
// Width-parameterised saturating event counter with asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        // Hold at all-ones rather than wrapping.
        if (inc && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall bubbles and multi-cycle branch squash,
// with saturating counters of stalls and squashes taken.
module id_ex_hazard_ctrl
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_1,
    input  logic [4:0]       Rd_1,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UsesRt_ID,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // The branch cycle is the first squash cycle; SQUASH covers the remaining ones.
    localparam logic [SquashCntW-1:0] SqLoad =
        (FLUSH_CYCLES >= 2) ? SquashCntW'(FLUSH_CYCLES - 2) : '0;

    hz_state_e              state_q, state_d;
    logic [SquashCntW-1:0]  sq_cnt_q, sq_cnt_d;
    hz_ctrl_t               ctrl;
    logic                   lu;
    logic                   stall_evt;
    logic                   flush_evt;

    assign lu = load_use(MemRead_1, Rd_1, Rs_ID, Rt_ID, UsesRt_ID);

    always_comb begin
        state_d   = state_q;
        sq_cnt_d  = sq_cnt_q;
        ctrl      = CtrlNormal;
        stall_evt = 1'b0;
        flush_evt = 1'b0;
        unique case (state_q)
            StRun, StBubble: begin
                if (BranchTaken) begin
                    ctrl      = CtrlSquash;
                    flush_evt = 1'b1;
                    if (FLUSH_CYCLES == 1) begin
                        state_d  = StRun;
                        sq_cnt_d = '0;
                    end else begin
                        state_d  = StSquash;
                        sq_cnt_d = SqLoad;
                    end
                end else if ((state_q == StRun) && lu) begin
                    ctrl      = CtrlStall;
                    stall_evt = 1'b1;
                    state_d   = StBubble;
                end else begin
                    state_d = StRun;
                end
            end
            StSquash: begin
                ctrl = CtrlSquash;
                if (sq_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    sq_cnt_d = sq_cnt_q - SquashCntW'(1);
                end
            end
            default: begin
                state_d  = StRun;
                sq_cnt_d = '0;
            end
        endcase
        // Reset overrides the outputs asynchronously, not just at the next edge.
        if (reset) begin
            ctrl      = CtrlReset;
            stall_evt = 1'b0;
            flush_evt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StRun;
            sq_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    assign PCWrite   = ctrl.pc_write;
    assign IFIDWrite = ctrl.ifid_write;
    assign IFIDFlush = ctrl.ifid_flush;
    assign IDEXFlush = ctrl.idex_flush;

    sat_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_evt),
        .count (StallCount)
    );

    sat_counter #(
        .Width (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_evt),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl: three configurations share one stimulus stream.
module tb_id_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mr = 1'b0;
    logic [4:0] rd = '0;
    logic [4:0] rs = '0;
    logic [4:0] rt = '0;
    logic       urt = 1'b0;
    logic       br = 1'b0;

    logic        pcw_a, ifw_a, iff_a, idf_a;
    logic        pcw_b, ifw_b, iff_b, idf_b;
    logic        pcw_c, ifw_c, iff_c, idf_c;
    logic [15:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;

    int total = 0;
    int bad = 0;
    int es = 0;
    int ef = 0;

    typedef struct {
        string      tag;
        int         dut;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // a: FLUSH_CYCLES=2; b: FLUSH_CYCLES=3; c: FLUSH_CYCLES=2 with 4-bit counters
    id_ex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .MemRead_1(mr), .Rd_1(rd), .Rs_ID(rs), .Rt_ID(rt),
        .UsesRt_ID(urt), .BranchTaken(br), .PCWrite(pcw_a), .IFIDWrite(ifw_a),
        .IFIDFlush(iff_a), .IDEXFlush(idf_a), .StallCount(sc_a), .FlushCount(fc_a));

    id_ex_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .MemRead_1(mr), .Rd_1(rd), .Rs_ID(rs), .Rt_ID(rt),
        .UsesRt_ID(urt), .BranchTaken(br), .PCWrite(pcw_b), .IFIDWrite(ifw_b),
        .IFIDFlush(iff_b), .IDEXFlush(idf_b), .StallCount(sc_b), .FlushCount(fc_b));

    id_ex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .MemRead_1(mr), .Rd_1(rd), .Rs_ID(rs), .Rt_ID(rt),
        .UsesRt_ID(urt), .BranchTaken(br), .PCWrite(pcw_c), .IFIDWrite(ifw_c),
        .IFIDFlush(iff_c), .IDEXFlush(idf_c), .StallCount(sc_c), .FlushCount(fc_c));

    function automatic logic [3:0] obs_outs(input int d);
        case (d)
            0:       return {pcw_a, ifw_a, iff_a, idf_a};
            1:       return {pcw_b, ifw_b, iff_b, idf_b};
            default: return {pcw_c, ifw_c, iff_c, idf_c};
        endcase
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs are {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}.
    task automatic expect_now(input string tag, input logic [3:0] ea, input logic [3:0] eb);
        exp_t e;
        sb.push_back('{tag: tag, dut: 0, exp: ea});
        sb.push_back('{tag: tag, dut: 1, exp: eb});
        sb.push_back('{tag: tag, dut: 2, exp: ea});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (obs_outs(e.dut) === e.exp) else begin
                bad++;
                $error("FAIL %s dut%0d outs observed=%b expected=%b",
                       e.tag, e.dut, obs_outs(e.dut), e.exp);
            end
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall_a"}, int'(sc_a), es);
        chk({tag, "_flush_a"}, int'(fc_a), ef);
        chk({tag, "_stall_b"}, int'(sc_b), es);
        chk({tag, "_flush_b"}, int'(fc_b), ef);
        chk({tag, "_stall_c"}, int'(sc_c), sat15(es));
        chk({tag, "_flush_c"}, int'(fc_c), sat15(ef));
    endtask

    task automatic drive(input logic m, input logic [4:0] d, input logic [4:0] s,
                         input logic [4:0] t, input logic u, input logic b);
        mr = m; rd = d; rs = s; rt = t; urt = u; br = b;
    endtask

    // One cycle: drive after the edge, check mid-cycle (counters reflect prior edges).
    task automatic cyc(input string tag, input logic m, input logic [4:0] d,
                       input logic [4:0] s, input logic [4:0] t, input logic u,
                       input logic b, input logic [3:0] ea, input logic [3:0] eb);
        @(posedge clk);
        #1;
        drive(m, d, s, t, u, b);
        #3;
        expect_now(tag, ea, eb);
        chk_cnt(tag);
    endtask

    localparam logic [3:0] ON = 4'b1100;
    localparam logic [3:0] OS = 4'b0001;
    localparam logic [3:0] OQ = 4'b1011;
    localparam logic [3:0] OR = 4'b0011;

    initial begin
        #2;
        expect_now("reset", OR, OR);
        chk_cnt("reset");
        @(negedge clk);
        reset = 1'b0;

        cyc("idle",      0, 5'd0, 5'd0, 5'd0, 0, 0, ON, ON);
        cyc("lu_rs",     1, 5'd5, 5'd5, 5'd0, 0, 0, OS, OS);
        es++;
        cyc("bubble",    1, 5'd5, 5'd5, 5'd0, 0, 0, ON, ON);
        cyc("run_after", 0, 5'd0, 5'd0, 5'd0, 0, 0, ON, ON);
        cyc("rd_zero",   1, 5'd0, 5'd0, 5'd0, 0, 0, ON, ON);
        cyc("rt_unused", 1, 5'd7, 5'd0, 5'd7, 0, 0, ON, ON);
        cyc("lu_rt",     1, 5'd7, 5'd0, 5'd7, 1, 0, OS, OS);
        es++;
        cyc("bubble2",   0, 5'd0, 5'd0, 5'd0, 0, 0, ON, ON);

        // Branch with a simultaneous load-use; branch wins, no stall counted.
        cyc("br_lu",     1, 5'd5, 5'd5, 5'd0, 0, 1, OQ, OQ);
        ef++;
        cyc("sq_br_in",  0, 5'd0, 5'd0, 5'd0, 0, 1, OQ, OQ);
        cyc("sq_end",    0, 5'd0, 5'd0, 5'd0, 0, 0, ON, OQ);
        cyc("sq_done",   0, 5'd0, 5'd0, 5'd0, 0, 0, ON, ON);

        // Reset in the second squash cycle aborts it asynchronously.
        cyc("br2",       0, 5'd0, 5'd0, 5'd0, 0, 1, OQ, OQ);
        ef++;
        @(posedge clk);
        #1;
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0);
        #1;
        expect_now("sq_mid", OQ, OQ);
        reset = 1'b1;
        #1;
        expect_now("rst_async", OR, OR);
        es = 0;
        ef = 0;
        chk_cnt("rst_async");
        @(negedge clk);
        reset = 1'b0;
        cyc("post_rst",  0, 5'd0, 5'd0, 5'd0, 0, 0, ON, ON);
        cyc("lu_post",   1, 5'd9, 5'd0, 5'd9, 1, 0, OS, OS);
        es++;
        cyc("bub_post",  1, 5'd9, 5'd0, 5'd9, 1, 0, ON, ON);

        // Back-to-back load-use: the 4-bit counter must pin at 15.
        for (int i = 0; i < 20; i++) begin
            cyc("lu_loop",  1, 5'd3, 5'd3, 5'd0, 0, 0, OS, OS);
            es++;
            cyc("bub_loop", 1, 5'd3, 5'd3, 5'd0, 0, 0, ON, ON);
        end
        cyc("final",     0, 5'd0, 5'd0, 5'd0, 0, 0, ON, ON);
        chk("stall_sat_c", int'(sc_c), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
